// File: rtl/ctrl_types_pkg.sv
// Command opcodes and controller state encoding for the key-value cache controller.
package ctrl_types_pkg;

   typedef enum logic [2:0] {
      OP_NOOP  = 3'd0,
      OP_GET   = 3'd1,
      OP_PUT   = 3'd2,
      OP_DEL   = 3'd3,
      OP_FLUSH = 3'd4
   } operation_e;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      EXEC
   } ctrl_state_e;

   function automatic logic is_legal_op(input logic [2:0] op);
      return (op != 3'd0) && (op <= 3'd4);
   endfunction

endpackage

// File: rtl/if_types_pkg.sv
// Register-interface types shared between the OBI register block and its command controllers.
package if_types_pkg;

   localparam int unsigned RegKeyWidth  = 32;
   localparam int unsigned RegDataWidth = 32;

   typedef struct packed {
      logic [RegKeyWidth-1:0]  key;
      logic [RegDataWidth-1:0] dat;
      logic [2:0]              operation;
   } reg_read_t;

   typedef struct packed {
      logic [RegDataWidth-1:0] dat;
      logic                    data_valid;
      logic                    busy;
      logic                    busy_valid;
      logic [2:0]              operation;
      logic                    operation_valid;
   } reg_write_t;

endpackage

// File: rtl/cache_kv_store.sv
// Fully-associative key/value storage: async read at one index, single write port, bulk invalidate.
module cache_kv_store #(
   parameter int unsigned NumEntries = 8,
   parameter int unsigned KeyWidth   = 32,
   parameter int unsigned DataWidth  = 32,
   localparam int unsigned IdxW      = $clog2(NumEntries)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [IdxW-1:0]      rd_idx_i,
   output logic [KeyWidth-1:0]  rd_key_o,
   output logic [DataWidth-1:0] rd_dat_o,
   output logic                 rd_valid_o,
   input  logic                 wr_en_i,
   input  logic [IdxW-1:0]      wr_idx_i,
   input  logic [KeyWidth-1:0]  wr_key_i,
   input  logic [DataWidth-1:0] wr_dat_i,
   input  logic                 wr_valid_i,
   input  logic                 flush_i
);

   logic [KeyWidth-1:0]   key_q [NumEntries];
   logic [DataWidth-1:0]  dat_q [NumEntries];
   logic [NumEntries-1:0] valid_q;

   assign rd_key_o   = key_q[rd_idx_i];
   assign rd_dat_o   = dat_q[rd_idx_i];
   assign rd_valid_o = valid_q[rd_idx_i];

   // Payload arrays carry no reset; only the valid bits define store contents.
   always_ff @(posedge clk) begin
      if (wr_en_i && wr_valid_i) begin
         key_q[wr_idx_i] <= wr_key_i;
         dat_q[wr_idx_i] <= wr_dat_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
      end else if (flush_i) begin
         valid_q <= '0;
      end else if (wr_en_i) begin
         valid_q[wr_idx_i] <= wr_valid_i;
      end
   end

endmodule

// File: rtl/redis_cache_ctrl.sv
// GET/PUT/DEL/FLUSH command sequencer: captures a register command, scans the store, executes in one cycle.
module redis_cache_ctrl
   import if_types_pkg::*;
   import ctrl_types_pkg::*;
#(
   parameter int unsigned NumEntries = 8,
   parameter int unsigned KeyWidth   = RegKeyWidth,
   parameter int unsigned DataWidth  = RegDataWidth,
   localparam int unsigned IdxW      = $clog2(NumEntries),
   localparam int unsigned CntW      = $clog2(NumEntries + 1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  reg_read_t       reg_read_i,
   output reg_write_t      reg_write_o,
   output logic            hit_o,
   output logic [CntW-1:0] count_o,
   output logic            full_o
);

   ctrl_state_e          state_q;
   operation_e           op_q;
   logic [KeyWidth-1:0]  key_q;
   logic [DataWidth-1:0] dat_q;
   logic [IdxW-1:0]      idx_q;
   logic                 match_q;
   logic                 free_found_q;
   logic [IdxW-1:0]      free_idx_q;
   logic [IdxW-1:0]      victim_q;
   logic [CntW-1:0]      count_q;
   logic                 hit_q;

   logic [KeyWidth-1:0]  st_key;
   logic [DataWidth-1:0] st_dat;
   logic                 st_valid;
   logic                 wr_en;
   logic [IdxW-1:0]      wr_idx;
   logic                 wr_valid;
   logic                 flush;

   cache_kv_store #(
      .NumEntries (NumEntries),
      .KeyWidth   (KeyWidth),
      .DataWidth  (DataWidth)
   ) u_store (
      .clk        (clk),
      .rst_n      (rst_n),
      .rd_idx_i   (idx_q),
      .rd_key_o   (st_key),
      .rd_dat_o   (st_dat),
      .rd_valid_o (st_valid),
      .wr_en_i    (wr_en),
      .wr_idx_i   (wr_idx),
      .wr_key_i   (key_q),
      .wr_dat_i   (dat_q),
      .wr_valid_i (wr_valid),
      .flush_i    (flush)
   );

   // idx_q freezes on a hit, so in EXEC it doubles as the matched index.
   always_comb begin
      wr_en    = 1'b0;
      wr_idx   = idx_q;
      wr_valid = 1'b0;
      flush    = 1'b0;
      if (state_q == EXEC) begin
         unique case (op_q)
            OP_PUT: begin
               wr_en    = 1'b1;
               wr_valid = 1'b1;
               if (!match_q) wr_idx = free_found_q ? free_idx_q : victim_q;
            end
            OP_DEL:   wr_en = match_q;
            OP_FLUSH: flush = 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      reg_write_o = '0;
      unique case (state_q)
         IDLE: begin
            if (reg_read_i.operation != OP_NOOP) begin
               reg_write_o.operation_valid = 1'b1;
               reg_write_o.operation       = OP_NOOP;
               if (is_legal_op(reg_read_i.operation)) begin
                  reg_write_o.busy_valid = 1'b1;
                  reg_write_o.busy       = 1'b1;
               end
            end
         end
         EXEC: begin
            reg_write_o.busy_valid = 1'b1;
            if (op_q == OP_GET) begin
               reg_write_o.data_valid = 1'b1;
               reg_write_o.dat        = match_q ? st_dat : '0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         op_q         <= OP_NOOP;
         key_q        <= '0;
         dat_q        <= '0;
         idx_q        <= '0;
         match_q      <= 1'b0;
         free_found_q <= 1'b0;
         free_idx_q   <= '0;
         victim_q     <= '0;
         count_q      <= '0;
         hit_q        <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (is_legal_op(reg_read_i.operation)) begin
                  op_q         <= operation_e'(reg_read_i.operation);
                  key_q        <= reg_read_i.key;
                  dat_q        <= reg_read_i.dat;
                  idx_q        <= '0;
                  match_q      <= 1'b0;
                  free_found_q <= 1'b0;
                  state_q      <= (reg_read_i.operation == OP_FLUSH) ? EXEC : SCAN;
               end
            end
            SCAN: begin
               if (!st_valid && !free_found_q) begin
                  free_found_q <= 1'b1;
                  free_idx_q   <= idx_q;
               end
               if (st_valid && (st_key == key_q)) begin
                  match_q <= 1'b1;
                  state_q <= EXEC;
               end else if (idx_q == IdxW'(NumEntries - 1)) begin
                  state_q <= EXEC;
               end else begin
                  idx_q <= idx_q + IdxW'(1);
               end
            end
            EXEC: begin
               state_q <= IDLE;
               unique case (op_q)
                  OP_GET: hit_q <= match_q;
                  OP_PUT: begin
                     hit_q <= match_q;
                     if (!match_q) begin
                        if (free_found_q) begin
                           count_q <= count_q + CntW'(1);
                        end else begin
                           victim_q <= (victim_q == IdxW'(NumEntries - 1)) ? '0 : victim_q + IdxW'(1);
                        end
                     end
                  end
                  OP_DEL: begin
                     hit_q <= match_q;
                     if (match_q) count_q <= count_q - CntW'(1);
                  end
                  OP_FLUSH: begin
                     count_q  <= '0;
                     victim_q <= '0;
                  end
                  default: ;
               endcase
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign hit_o   = hit_q;
   assign count_o = count_q;
   assign full_o  = (count_q == CntW'(NumEntries));

endmodule
